mix_columns_seq: RTL and testbench
==================================

# mix_columns_seq

Iterative forward AES MixColumns engine: accepts a 128-bit state over a valid/ready handshake and multiplies each 32-bit column by the fixed MixColumns matrix over GF(2^8). It processes COLS_PER_CYCLE columns per clock and presents the registered 128-bit result over a second valid/ready handshake. It is the encryption-direction counterpart of the inverse MixColumns stage and sits between ShiftRows and AddRoundKey in the encrypt round datapath.

## Interface
- COLS_PER_CYCLE, 1, columns computed per clock; legal values 1, 2 and 4; any other value is a configuration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state (high only in IDLE).
- in_data  input  128  state: column c = bits [127-32c -: 32], row 0 is the MSB byte of each column.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  MixColumns result, same byte layout as in_data.

## Operation
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); 3·b = xtime(b) ^ b. All arithmetic is 8-bit GF(2^8); there is no carry.
- For a column (a0,a1,a2,a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- N = 4/COLS_PER_CYCLE (N = 4, 2 or 1).
- State machine IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_data into the working register, clear the column counter, go to BUSY.
- BUSY:
  - Each cycle, compute COLS_PER_CYCLE columns starting at counter×COLS_PER_CYCLE, in order column 0 first.
  - Write each result back into its column position of the working register; advance the counter.
  - After the N-th cycle, go to DONE.
- DONE:
  - out_valid = 1; out_data = working register.
  - On out_ready: go to IDLE.
  - out_data and out_valid stay stable while out_ready = 0 (no timeout).
- in_valid is ignored outside IDLE. in_data is not required to be held after acceptance.
- Column counter width is 2 bits. It never wraps mid-block because the BUSY exit is taken at count N-1.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, out_data = 128'h0, counter = 0.
- rst_n asserted at any time, including mid-BUSY or in DONE: all state returns to its reset value immediately, the in-flight block is discarded and no partial result is ever presented.
- Latency: input accepted at edge k → out_valid high after edge k+N.
- Minimum issue interval is N+2 cycles: accept, N compute cycles, output handshake, return to IDLE.
- out_valid & out_ready at edge m → out_valid low and in_ready high after edge m. The next input is accepted at edge m+1 or later; in_ready is never high in the same cycle as out_valid.
- out_ready high while not in DONE has no effect.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

## Test plan
- FIPS-197 column vectors, COLS_PER_CYCLE = 1, with each input below placed in column 0 → exact column-0 outputs:
  - db135345 → 8e4da1bc
  - f20a225c → 9fdc589d
  - d4d4d4d5 → d5d5d7d6
  - 2d26314c → 4d7ebdf8
  - 01010101 → 01010101
  - c6c6c6c6 → c6c6c6c6
- Full state, FIPS-197 Appendix B round 1, input d4bf5d30e0b452aeb84111f11e2798e5 → 046681e5e0cb199a48f8d37a2806264c. Run at COLS_PER_CYCLE = 1, 2 and 4; out_valid must rise exactly 4, 2 and 1 cycles after acceptance respectively.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_data constant, in_ready stays 0, and an in_valid pulse with a different state is ignored. Then out_ready = 1 → IDLE on the next cycle.
- Back-to-back: drive 8 random states with in_valid held high and out_ready held high → 8 results in order, each matching a software model, with issue interval exactly N+2.
- Reset mid-operation: assert rst_n low during the second BUSY cycle → out_valid = 0, out_data = 0 and in_ready = 1 during reset. The next accepted block produces the correct result with no residue from the aborted block.
- xtime edge bytes: all-80 state → every column 80808080; all-ff state → every column ffffffff; all-00 state → all-00.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Iterative forward AES MixColumns: captures a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until it is taken.

module mix_col (
    input  logic [31:0] a,
    output logic [31:0] b
);
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = a;

    // 3*x is folded as xtime(x) ^ x
    assign b[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign b[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign b[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign b[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
endmodule

module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int N = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(N - 1);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_cfg_err
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [1:0] cnt;
    // work[3] holds column 0 so the packed layout matches in_data bit-for-bit
    logic [3:0][31:0] work;

    logic [COLS_PER_CYCLE-1:0][1:0]  slot;
    logic [COLS_PER_CYCLE-1:0][31:0] col_in;
    logic [COLS_PER_CYCLE-1:0][31:0] col_out;

    generate
        for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
            assign slot[l]   = 2'd3 - 2'(int'(cnt) * COLS_PER_CYCLE + l);
            assign col_in[l] = work[slot[l]];
        end
    endgenerate

    mix_col u_mix [COLS_PER_CYCLE-1:0] (
        .a (col_in),
        .b (col_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        cnt      <= 2'd0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < COLS_PER_CYCLE; l++)
                        work[slot[l]] <= col_out[l];
                    if (cnt == LAST) begin
                        cnt       <= 2'd0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gate so partially transformed columns never appear on the output
    assign out_data = out_valid ? work : '0;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// checked against a generic GF(2^8) matrix-multiply model.

module tb_mix_columns_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic [127:0] in_data   [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_data  [3];

    int tests = 0;
    int fails = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]));

    // Shift-and-add multiply over GF(2^8) with the AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        base = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - row) & 3], a[k]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Feed one state, wait for out_valid; lat counts edges from acceptance
    task automatic run_block(input int d, input logic [127:0] data, input bit release_out,
                             output logic [127:0] res, output int lat);
        int n;
        @(negedge clk);
        in_data[d]   = data;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        n = 0;
        while (!in_ready[d] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = rnd128();
        lat = 0;
        while (!out_valid[d] && lat < 20) begin @(posedge clk); #1; lat++; end
        res = out_data[d];
        if (release_out && out_valid[d]) begin
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1 out_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== 128'h0) begin
                fails++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                         d, in_ready[d], out_valid[d], out_data[d]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_fips_columns();
        logic [31:0]  cin  [6];
        logic [31:0]  cout [6];
        logic [127:0] s, res;
        int lat;
        cin  = '{32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6};
        cout = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6};
        for (int i = 0; i < 6; i++) begin
            s = {cin[i], $urandom(), $urandom(), $urandom()};
            run_block(0, s, 1'b1, res, lat);
            tests++;
            if (res[127:96] !== cout[i] || res !== mix_model(s)) begin
                fails++;
                $display("FAIL fips_col%0d: got %h, want col0 %h full %h", i, res, cout[i], mix_model(s));
            end
        end
    endtask

    task automatic test_full_state();
        logic [127:0] res;
        int lat;
        for (int d = 0; d < 3; d++) begin
            run_block(d, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, res, lat);
            tests++;
            if (res !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
                fails++;
                $display("FAIL full_state dut%0d: got %h, want 046681e5e0cb199a48f8d37a2806264c", d, res);
            end
            tests++;
            if (lat !== (4 >> d)) begin
                fails++;
                $display("FAIL latency dut%0d: got %0d, want %0d", d, lat, 4 >> d);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s, res, exp;
        int lat;
        s   = rnd128();
        exp = mix_model(s);
        run_block(0, s, 1'b0, res, lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid[0] = 1'b1; in_data[0] = ~s; end
            if (i == 4) in_valid[0] = 1'b0;
            @(posedge clk);
            #1;
            tests++;
            if (out_data[0] !== exp || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                fails++;
                $display("FAIL backpressure cyc%0d: out_data=%h out_valid=%b in_ready=%b, want %h 1 0",
                         i, out_data[0], out_valid[0], in_ready[0], exp);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL bp_ignored_input: in_ready=%b, want 1 (stays idle)", in_ready[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [8];
        int acc_t [8];
        int ai, oi, cyc, nn;
        for (int d = 0; d < 3; d++) begin
            nn = 4 >> d;
            for (int i = 0; i < 8; i++) begin st[i] = rnd128(); acc_t[i] = 0; end
            ai = 0; oi = 0; cyc = 0;
            out_ready[d] = 1'b1;
            while (oi < 8 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (out_valid[d]) begin
                    tests++;
                    if (out_data[d] !== mix_model(st[oi]) || in_ready[d] !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b dut%0d blk%0d: got %h in_ready=%b, want %h 0",
                                 d, oi, out_data[d], in_ready[d], mix_model(st[oi]));
                    end
                    oi++;
                end
                in_valid[d] = (ai < 8);
                if (ai < 8) in_data[d] = st[ai];
                if (in_ready[d] && ai < 8) begin acc_t[ai] = cyc; ai++; end
            end
            @(negedge clk);
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            if (oi < 8) begin
                tests++; fails++;
                $display("FAIL b2b_timeout dut%0d: got %0d results, want 8", d, oi);
            end
            for (int i = 1; i < 8; i++) begin
                tests++;
                if (acc_t[i] - acc_t[i-1] !== nn + 2) begin
                    fails++;
                    $display("FAIL b2b_interval dut%0d blk%0d: got %0d, want %0d",
                             d, i, acc_t[i] - acc_t[i-1], nn + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] s, res;
        int lat;
        @(negedge clk);
        in_data[0]  = rnd128();
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: out_valid=%b out_data=%h in_ready=%b, want 0 0 1",
                     out_valid[0], out_data[0], in_ready[0]);
        end
        @(negedge clk) rst_n = 1'b1;
        s = rnd128();
        run_block(0, s, 1'b1, res, lat);
        tests++;
        if (res !== mix_model(s) || lat !== 4) begin
            fails++;
            $display("FAIL reset_mid_next: got %h lat %0d, want %h lat 4", res, lat, mix_model(s));
        end
    endtask

    task automatic test_xtime_edges();
        logic [127:0] vin  [3];
        logic [127:0] vout [3];
        logic [127:0] res;
        int lat;
        vin  = '{{16{8'h80}}, {16{8'hff}}, 128'h0};
        vout = '{{16{8'h80}}, {16{8'hff}}, 128'h0};
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) begin
                run_block(d, vin[i], 1'b1, res, lat);
                tests++;
                if (res !== vout[i]) begin
                    fails++;
                    $display("FAIL xtime_edge dut%0d v%0d: got %h, want %h", d, i, res, vout[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips_columns();
        test_full_state();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_xtime_edges();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
